rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one resource, such as a bus or datapath slot, between four clients. It registers a 2-bit owner index and drives a one-hot grant vector decoded from that index. Ownership is held until the owner drops its request or a hold limit expires. Sits between client request lines and the shared resource's select/enable inputs.

---
 rtl/arb_pkg.sv | 12 +
 rtl/dec2to4.sv | 17 +
 rtl/rr_arbiter4.sv | 101 ++++++++++
 tb/tb_rr_arbiter4.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

endpackage

// File: rtl/dec2to4.sv
// Two-to-four one-hot decoder with enable; all-zero output when disabled.
module dec2to4
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered owner index,
// a per-grant hold limit and a mandatory idle turnaround after each release.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // Handshake: client i may use the resource in every cycle gnt[i]=1 and
    // keeps it by holding req[i]; dropping req[i] releases it at the next edge.
    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [CNT_W-1:0] hold_cnt;
    logic             owner_req;
    logic             hold_expired;
    logic             timeout_q;

    // First set request at or after ptr, wrapping 3 -> 0.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = ptr;
        win_found = 1'b0;
        win_idx   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req    = req[gnt_idx];
    assign hold_expired = (hold_cnt == CNT_W'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt_idx   <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        gnt_idx  <= win_idx;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        ptr <= gnt_idx + IDX_W'(1);
                    end else if (hold_expired) begin
                        ptr       <= gnt_idx + IDX_W'(1);
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Any release returns to IDLE, so the turnaround cycle is never skipped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (win_found) state_next = ST_GRANT;
            ST_GRANT: if (!owner_req || hold_expired) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_valid = (state == ST_GRANT);
        timeout   = timeout_q;
    end

    dec2to4 u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: a cycle model pushes the expected outputs
// for every edge, and they are compared just after that edge.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    // Reference model: owner (-1 = idle), search pointer, cycles held so far.
    int         m_own  = -1;
    logic [1:0] m_ptr  = 2'b00;
    int         m_held = 0;
    logic       m_to   = 1'b0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] observed();
        return {timeout, gnt_valid, (gnt_valid ? gnt_idx : 2'b00), gnt};
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_ptr  = 2'b00;
        m_held = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int         c;
        logic [3:0] g;
        logic       v;
        logic [1:0] ix;
        m_to = 1'b0;
        if (m_own < 0) begin
            for (int i = 0; i < 4; i++) begin
                c = (int'(m_ptr) + i) % 4;
                if (m_own < 0 && r[c]) begin
                    m_own  = c;
                    m_held = 1;
                end
            end
        end else if (!r[m_own]) begin
            m_ptr = 2'((m_own + 1) % 4);
            m_own = -1;
        end else if (m_held == HOLD_MAX) begin
            m_ptr = 2'((m_own + 1) % 4);
            m_own = -1;
            m_to  = 1'b1;
        end else begin
            m_held++;
        end
        v  = (m_own >= 0);
        g  = v ? 4'(1 << m_own) : 4'b0000;
        ix = v ? 2'(m_own) : 2'b00;
        exp_q.push_back({m_to, v, ix, g});
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %h expected <queue empty>", tag, observed());
        end else begin
            check(tag, observed(), exp_q.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         owners[$];
        int         exp_order[5];
        int         to_count;
        logic       prev_v;
        logic [3:0] r;

        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {timeout, gnt_valid, gnt_idx, gnt}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Full contention: rotation 0,1,2,3,0 with a timeout at each revoke.
        to_count = 0;
        prev_v   = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step(4'b1111, "rotate");
            if (gnt_valid && !prev_v) owners.push_back(int'(gnt_idx));
            prev_v = gnt_valid;
            if (timeout) to_count++;
        end
        check("rot_grants", 8'(owners.size()), 8'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rot_owner%0d", i),
                  (i < owners.size()) ? 8'(owners[i]) : 8'hff, 8'(exp_order[i]));
        end
        check("rot_timeouts", 8'(to_count), 8'd5);
        step(4'b0000, "rot_drain");

        // Client 2 holds three cycles then drops; pointer moves to 3.
        repeat (3) step(4'b0100, "hold2");
        step(4'b0000, "drop2");
        step(4'b0000, "idle2");
        step(4'b1111, "ptr3");

        // Owner 3 releases while 0 and 2 request: winner wraps to 0.
        step(4'b0101, "rel3");
        step(4'b0101, "wrap0");
        step(4'b0101, "hold0");
        step(4'b0100, "rel0");
        step(4'b0110, "ptr1");

        // Non-owner one-cycle pulse while client 1 owns.
        step(4'b0010, "own1");
        step(4'b0110, "pulse2");
        step(4'b0010, "own1b");
        step(4'b0000, "rel1");
        step(4'b0000, "idle1");

        // Asynchronous reset between edges during a grant.
        step(4'b0010, "pre_rst");
        step(4'b0010, "pre_rst2");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {timeout, gnt_valid, gnt_idx, gnt}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1000, "post_rst");
        step(4'b0000, "post_rel");

        // Single-cycle request.
        step(4'b0001, "single");
        step(4'b0000, "single_rel");
        step(4'b0000, "single_idle");

        // Random traffic, half the time holding the previous pattern.
        r = 4'b0000;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
            step(r, "random");
        end
        step(4'b0000, "final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
